result_checker: RTL and testbench
=================================

// Module: result_checker
// PURPOSE
//  Hardware scoreboard downstream of the DAG processor's output write-back. Streams
//  result words, fetches the matching golden word from a preloaded golden memory and
//  compares within an absolute tolerance, the same criterion as verif_data.
//  Reports pass/fail, error count and first mismatch.
//  Used in FPGA/emulation runs where no testbench is available.
// PARAMETERS
//  CNT_W    16  width of result index and counters; max 2**CNT_W-1 results per run
//  TOL_SH   10  tolerance exponent; a result passes iff |gold - sim| <= 2**TOL_SH
//  BIT_L    pkg word width (hw_config_pkg::BIT_L); word_t = logic [BIT_L-1:0]
// PORTS
//  clk            in   1       clock
//  rst            in   1       async reset, active low
//  start          in   1       1-cycle pulse: begin run (honoured only in IDLE/DONE)
//  n_results      in   CNT_W   number of results expected; sampled on start
//  res_vld        in   1       result word valid
//  res_rdy        out  1       checker accepts result this cycle
//  res_data       in   BIT_L   result word (unsigned fixed point)
//  gold_rd_en     out  1       golden memory read strobe
//  gold_rd_addr   out  CNT_W   golden memory address = result index
//  gold_rd_data   in   BIT_L   golden word, valid exactly 1 cycle after gold_rd_en
//  busy           out  1       high in RUN and DRAIN
//  done           out  1       high in DONE
//  pass           out  1       valid in DONE: err_cnt == 0
//  err_cnt        out  CNT_W   mismatches so far; saturates at all-ones
//  first_err_idx  out  CNT_W   index of first mismatch; held after capture
//  first_err_gold out  BIT_L   golden word of first mismatch
//  first_err_sim  out  BIT_L   simulated word of first mismatch
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; idx=0; stage-2 valid=0; first_err_* = 0.
//  FSM states:
//  - IDLE --start--> RUN; n_results=0 goes to DONE instead.
//  - RUN --(accepted count == n_results)--> DRAIN.
//  - DRAIN --(stage-2 empty)--> DONE.
//  - DONE --start--> RUN (re-arm) or DONE (n_results=0).
//  Start: latch n_results. Clear idx, err_cnt and first_err_* plus its captured flag.
//  start in RUN/DRAIN is ignored.
//  res_rdy = (state==RUN) && (idx < n_lat); combinational, no dependency on res_vld.
//  Stage 1 (accept): on res_vld&&res_rdy drive gold_rd_en=1 and gold_rd_addr=idx
//   combinationally; register res_data, idx and s2_vld=1; idx++.
//  Stage 2 (compare, +1 cycle): diff = |gold_rd_data - sim_q| computed at BIT_L+1 bits.
//   No wrap-around; fixes the unsigned overflow in the old golden+2**10 form.
//   On mismatch (diff > 2**TOL_SH): err_cnt++ (saturating).
//   If no error captured yet: load first_err_*.
//  Throughput 1 result/cycle; latency accept->err_cnt update = 2 clk edges.
//  Extra res_vld after n_results are not accepted (res_rdy=0) and not counted.
//  pass/done registered; asserted the cycle FSM enters DONE, held until next start.
//  gold_rd_en never asserts outside accepted handshakes.
//  Async reset mid-run aborts immediately; the in-flight stage-2 compare is discarded.
// STRUCTURE
//  utils_pkg: add within_tol(word_t g, s, int sh) function (widened, symmetric) and
//   typedef enum {CHK_IDLE, CHK_RUN, CHK_DRAIN, CHK_DONE} chk_state_t.
//  word_t and BIT_L from hw_config_pkg. Single module, no sub-modules.
//  Stage 2 uses utils_pkg::within_tol so RTL and TB share one criterion.
// TESTING
//  1 n=4, gold=sim={10,20,30,40}, res_vld always 1
//    -> done 6 cycles after start, pass=1, err_cnt=0.
//  2 n=3, gold={5000,0,100}, sim={5000+1024,1025,100}
//    -> err_cnt=1, first_err_idx=1, gold=0, sim=1025.
//  3 Wrap check, BIT_L=32: gold=32'hFFFF_FF00, sim=32'h0000_0100
//    -> mismatch, not a false pass.
//  4 n=0, start -> done next cycle, pass=1, res_rdy never 1, gold_rd_en never 1.
//  5 n=8, res_vld random 50%, 10 words offered
//    -> exactly 8 accepted, addrs 0..7 in order.
//    -> start pulsed during RUN is ignored.
//  6 rst low during RUN at idx=3 -> all outputs 0 next cycle.
//    -> re-run with n=2 passes cleanly.

Source files
------------

// File: rtl/hw_config_pkg.sv
// Datapath word definition shared by the DAG processor and its checkers.
package hw_config_pkg;
  localparam int BIT_L = 32;
  typedef logic [BIT_L-1:0] word_t;
endpackage

// File: rtl/utils_pkg.sv
// Result-checker FSM encoding and the absolute-tolerance pass criterion.
package utils_pkg;
  import hw_config_pkg::*;

  typedef enum logic [1:0] {CHK_IDLE, CHK_RUN, CHK_DRAIN, CHK_DONE} chk_state_t;

  // One extra bit of headroom so |g - s| can never wrap near the top of the range.
  function automatic logic within_tol(word_t g, word_t s, int sh);
    logic [BIT_L:0] gw, sw, diff, tol;
    gw   = {1'b0, g};
    sw   = {1'b0, s};
    diff = (gw >= sw) ? (gw - sw) : (sw - gw);
    tol  = {{BIT_L{1'b0}}, 1'b1} << sh;
    return (diff <= tol);
  endfunction
endpackage

// File: rtl/result_checker.sv
// Streams result words against a golden memory, 1 result/cycle, compare lands 1 cycle after accept.
// res_rdy_o drops once n_results words are taken; golden reads issue only on accepted handshakes.
module result_checker
  import hw_config_pkg::*;
  import utils_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int TOL_SH = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_results_i,
  input  logic             res_vld_i,
  output logic             res_rdy_o,
  input  word_t            res_data_i,
  output logic             gold_rd_en_o,
  output logic [CNT_W-1:0] gold_rd_addr_o,
  input  word_t            gold_rd_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] first_err_idx_o,
  output word_t            first_err_gold_o,
  output word_t            first_err_sim_o
);

  chk_state_t       state_q, state_d;
  logic [CNT_W-1:0] n_lat_q, n_lat_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic [CNT_W-1:0] s2_idx_q;
  word_t            sim_q;
  word_t            fgold_q, fgold_d;
  word_t            fsim_q, fsim_d;
  logic             cap_q, cap_d;
  logic             s2_vld_q, s2_vld_d;
  logic             done_q, pass_q;
  logic             rdy, accept, start_ok, mismatch;

  always_comb begin
    rdy      = (state_q == CHK_RUN) && (idx_q < n_lat_q);
    accept   = rdy && res_vld_i;
    start_ok = start_i && ((state_q == CHK_IDLE) || (state_q == CHK_DONE));
    mismatch = s2_vld_q && !within_tol(gold_rd_data_i, sim_q, TOL_SH);

    state_d  = state_q;
    n_lat_d  = n_lat_q;
    idx_d    = idx_q;
    err_d    = err_q;
    cap_d    = cap_q;
    fidx_d   = fidx_q;
    fgold_d  = fgold_q;
    fsim_d   = fsim_q;
    s2_vld_d = accept;

    if (accept) idx_d = idx_q + CNT_W'(1);

    if (mismatch) begin
      if (err_q != '1) err_d = err_q + CNT_W'(1);
      if (!cap_q) begin
        cap_d   = 1'b1;
        fidx_d  = s2_idx_q;
        fgold_d = gold_rd_data_i;
        fsim_d  = sim_q;
      end
    end

    case (state_q)
      CHK_IDLE, CHK_DONE: begin
        if (start_ok) begin
          n_lat_d = n_results_i;
          idx_d   = '0;
          err_d   = '0;
          cap_d   = 1'b0;
          fidx_d  = '0;
          fgold_d = '0;
          fsim_d  = '0;
          state_d = (n_results_i == '0) ? CHK_DONE : CHK_RUN;
        end
      end
      CHK_RUN:   if (idx_d == n_lat_q) state_d = CHK_DRAIN;
      // The last compare retires on the edge that leaves DRAIN.
      CHK_DRAIN: if (!s2_vld_d) state_d = CHK_DONE;
      default:   state_d = CHK_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= CHK_IDLE;
      n_lat_q  <= '0;
      idx_q    <= '0;
      err_q    <= '0;
      cap_q    <= 1'b0;
      fidx_q   <= '0;
      fgold_q  <= '0;
      fsim_q   <= '0;
      s2_vld_q <= 1'b0;
      s2_idx_q <= '0;
      sim_q    <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_lat_q  <= n_lat_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      cap_q    <= cap_d;
      fidx_q   <= fidx_d;
      fgold_q  <= fgold_d;
      fsim_q   <= fsim_d;
      s2_vld_q <= s2_vld_d;
      if (accept) begin
        sim_q    <= res_data_i;
        s2_idx_q <= idx_q;
      end
      done_q   <= (state_d == CHK_DONE);
      pass_q   <= (state_d == CHK_DONE) && (err_d == '0);
    end
  end

  assign res_rdy_o        = rdy;
  assign gold_rd_en_o     = accept;
  assign gold_rd_addr_o   = accept ? idx_q : '0;
  assign busy_o           = (state_q == CHK_RUN) || (state_q == CHK_DRAIN);
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_cnt_o        = err_q;
  assign first_err_idx_o  = fidx_q;
  assign first_err_gold_o = fgold_q;
  assign first_err_sim_o  = fsim_q;

endmodule

// File: tb/tb_result_checker.sv
// Randomized bench for result_checker with an in-bench golden memory and behavioural scoreboard.
module tb_result_checker;
  import hw_config_pkg::*;

  localparam int CNT_W = 16;
  localparam longint TOL = 1024;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic [CNT_W-1:0] n_results_i = '0;
  logic             res_vld_i = 1'b0;
  logic             res_rdy_o;
  word_t            res_data_i = '0;
  logic             gold_rd_en_o;
  logic [CNT_W-1:0] gold_rd_addr_o;
  word_t            gold_rd_data_i = '0;
  logic             busy_o, done_o, pass_o;
  logic [CNT_W-1:0] err_cnt_o, first_err_idx_o;
  word_t            first_err_gold_o, first_err_sim_o;

  result_checker #(.CNT_W(CNT_W), .TOL_SH(10)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .n_results_i(n_results_i),
    .res_vld_i(res_vld_i), .res_rdy_o(res_rdy_o), .res_data_i(res_data_i),
    .gold_rd_en_o(gold_rd_en_o), .gold_rd_addr_o(gold_rd_addr_o),
    .gold_rd_data_i(gold_rd_data_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_cnt_o(err_cnt_o), .first_err_idx_o(first_err_idx_o),
    .first_err_gold_o(first_err_gold_o), .first_err_sim_o(first_err_sim_o)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  bit    chk_on = 1'b0;
  word_t gold_mem [256];
  word_t sim_w [64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: phase of the run, words taken so far, and the one compare in flight.
  int    m_phase, m_n, m_idx, m_err, m_pidx, m_fidx;
  bit    m_pend, m_cap, m_done, m_pass;
  word_t m_psim, m_fgold, m_fsim;

  always @(posedge clk or negedge rst_ni) begin : model
    bit     pend_b;
    longint d;
    if (!rst_ni) begin
      m_phase = P_IDLE; m_n = 0; m_idx = 0; m_err = 0; m_pidx = 0; m_fidx = 0;
      m_pend = 0; m_cap = 0; m_done = 0; m_pass = 0; m_psim = '0; m_fgold = '0; m_fsim = '0;
    end else begin
      pend_b = m_pend;
      m_pend = 0;
      if (pend_b) begin
        d = longint'(gold_mem[m_pidx]) - longint'(m_psim);
        if (d < 0) d = -d;
        if (d > TOL) begin
          if (m_err < 65535) m_err++;
          if (!m_cap) begin
            m_cap = 1; m_fidx = m_pidx; m_fgold = gold_mem[m_pidx]; m_fsim = m_psim;
          end
        end
      end
      case (m_phase)
        P_IDLE, P_DONE: if (start_i) begin
          m_n = int'(n_results_i); m_idx = 0; m_err = 0; m_cap = 0;
          m_fidx = 0; m_fgold = '0; m_fsim = '0;
          m_phase = (m_n == 0) ? P_DONE : P_RUN;
        end
        P_RUN: begin
          if (res_vld_i && m_idx < m_n) begin
            m_pend = 1; m_pidx = m_idx; m_psim = res_data_i; m_idx++;
          end
          if (m_idx == m_n) m_phase = P_DRAIN;
        end
        default: m_phase = P_DONE;
      endcase
      m_done = (m_phase == P_DONE);
      m_pass = m_done && (m_err == 0);
    end
  end

  always @(negedge clk) begin : compare
    bit exp_rdy;
    if (chk_on) begin
      exp_rdy = (m_phase == P_RUN) && (m_idx < m_n);
      chk("busy", busy_o, (m_phase == P_RUN) || (m_phase == P_DRAIN));
      chk("done", done_o, m_done);
      chk("pass", pass_o, m_pass);
      chk("err_cnt", err_cnt_o, m_err);
      chk("first_err_idx", first_err_idx_o, m_fidx);
      chk("first_err_gold", first_err_gold_o, m_fgold);
      chk("first_err_sim", first_err_sim_o, m_fsim);
      chk("res_rdy", res_rdy_o, exp_rdy);
      chk("gold_rd_en", gold_rd_en_o, exp_rdy && res_vld_i);
      if (gold_rd_en_o) chk("gold_rd_addr", gold_rd_addr_o, m_idx);
    end
  end

  // Golden memory: one-cycle read latency, junk on the bus when not read.
  bit               rd_pend = 1'b0;
  logic [CNT_W-1:0] rd_addr = '0;
  int               acc_log[$];

  always @(negedge clk) begin
    rd_pend = gold_rd_en_o;
    rd_addr = gold_rd_addr_o;
    if (gold_rd_en_o) acc_log.push_back(int'(gold_rd_addr_o));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    gold_rd_data_i = rd_pend ? gold_mem[rd_addr[7:0]] : word_t'($urandom());
  endtask

  // cyc = cycles from the start cycle until done_o is seen (start cycle counts as 0).
  task automatic do_run(input int n, input int offered, input int pct, input int mid_start,
                        output int cyc);
    int k;
    bit acc;
    tick();
    start_i = 1'b1; n_results_i = 16'(n); res_vld_i = 1'b0;
    tick();
    start_i = 1'b0;
    k = 0;
    cyc = -1;
    for (int c = 0; c < 600; c++) begin
      if (done_o) begin cyc = c + 1; break; end
      res_vld_i  = (k < offered) && ($urandom_range(99) < pct);
      res_data_i = sim_w[k % 64];
      start_i    = (c == mid_start);
      if (start_i) n_results_i = 16'd5;
      #1;
      acc = res_vld_i && res_rdy_o;
      tick();
      if (acc) k++;
      start_i = 1'b0;
    end
    res_vld_i = 1'b0;
    chk("run_reaches_done", cyc > 0, 1'b1);
  endtask

  function automatic int count_errs(input int n);
    longint d;
    int     e = 0;
    for (int i = 0; i < n; i++) begin
      d = longint'(gold_mem[i]) - longint'(sim_w[i]);
      if (d < 0) d = -d;
      if (d > TOL) e++;
    end
    return e;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int cyc, n, exp_e, off;
    int offs[6] = '{0, 1024, -1024, 1025, -1025, 7};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", done_o, 1'b0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_err", err_cnt_o, 0);
    chk("reset_rdy", res_rdy_o, 1'b0);
    chk_on = 1'b1;
    rst_ni = 1'b1;

    // 1: exact match, back-to-back
    for (int i = 0; i < 4; i++) begin gold_mem[i] = word_t'(10 * (i + 1)); sim_w[i] = gold_mem[i]; end
    do_run(4, 4, 100, -1, cyc);
    chk("t1_latency", cyc, 6);
    chk("t1_pass", pass_o, 1'b1);
    chk("t1_err", err_cnt_o, 0);

    // 2: tolerance boundary, exactly 2**10 passes and 2**10+1 fails
    gold_mem[0] = 32'd5000; gold_mem[1] = 32'd0;    gold_mem[2] = 32'd100;
    sim_w[0]    = 32'd6024; sim_w[1]    = 32'd1025; sim_w[2]    = 32'd100;
    do_run(3, 3, 100, -1, cyc);
    chk("t2_err", err_cnt_o, 1);
    chk("t2_first_idx", first_err_idx_o, 1);
    chk("t2_first_gold", first_err_gold_o, 0);
    chk("t2_first_sim", first_err_sim_o, 1025);
    chk("t2_pass", pass_o, 1'b0);

    // 3: values that would alias under a wrapping subtract
    gold_mem[0] = 32'hFFFF_FF00; sim_w[0] = 32'h0000_0100;
    do_run(1, 1, 100, -1, cyc);
    chk("t3_err", err_cnt_o, 1);
    chk("t3_pass", pass_o, 1'b0);

    // 4: empty run
    acc_log.delete();
    do_run(0, 2, 100, -1, cyc);
    chk("t4_latency", cyc, 1);
    chk("t4_pass", pass_o, 1'b1);
    res_vld_i = 1'b1;
    repeat (3) begin tick(); chk("t4_rdy_low", res_rdy_o, 1'b0); end
    res_vld_i = 1'b0;
    tick();
    chk("t4_no_reads", acc_log.size(), 0);

    // 5: 50% valid, surplus words, ignored restart mid-run
    for (int i = 0; i < 10; i++) begin
      gold_mem[i] = word_t'($urandom());
      sim_w[i]    = gold_mem[i] + word_t'(offs[i % 6]);
    end
    exp_e = count_errs(8);
    acc_log.delete();
    do_run(8, 10, 50, 3, cyc);
    chk("t5_accepted", acc_log.size(), 8);
    for (int i = 0; i < 8 && i < acc_log.size(); i++) chk("t5_addr_order", acc_log[i], i);
    chk("t5_err", err_cnt_o, exp_e);

    // random runs, offsets straddling the tolerance and the word boundary
    repeat (6) begin
      n = $urandom_range(20, 1);
      for (int i = 0; i < n + 2; i++) begin
        gold_mem[i] = word_t'($urandom());
        off = ($urandom_range(3) == 0) ? offs[$urandom_range(5)] : int'($urandom_range(2200)) - 1100;
        sim_w[i] = gold_mem[i] + word_t'(off);
      end
      exp_e = count_errs(n);
      do_run(n, n + 2, $urandom_range(100, 30), ($urandom_range(1) == 1) ? 2 : -1, cyc);
      chk("rnd_err", err_cnt_o, exp_e);
      chk("rnd_pass", pass_o, exp_e == 0);
    end

    // 6: reset mid-run with a mismatching compare still in flight
    for (int i = 0; i < 6; i++) begin gold_mem[i] = word_t'(1000 * i); sim_w[i] = gold_mem[i]; end
    sim_w[2] = gold_mem[2] + 32'd5000;
    tick();
    start_i = 1'b1; n_results_i = 16'd6;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin res_vld_i = 1'b1; res_data_i = sim_w[i]; tick(); end
    rst_ni = 1'b0;
    res_vld_i = 1'b0;
    #2;
    chk("t6_busy", busy_o, 1'b0);
    chk("t6_done", done_o, 1'b0);
    chk("t6_pass", pass_o, 1'b0);
    chk("t6_err", err_cnt_o, 0);
    chk("t6_rdy", res_rdy_o, 1'b0);
    chk("t6_gold_en", gold_rd_en_o, 1'b0);
    chk("t6_first_sim", first_err_sim_o, 0);
    tick();
    tick();
    chk("t6_err_after", err_cnt_o, 0);
    rst_ni = 1'b1;
    do_run(2, 2, 100, -1, cyc);
    chk("t6_rerun_pass", pass_o, 1'b1);
    chk("t6_rerun_err", err_cnt_o, 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
